// File: rtl/joint_step_driver.sv
// Step/direction generator for the two SCARA joints: tracks joint positions and steps both
// joints toward each new IK target on a shared timebase. Optional clamping: JOINT_LIMIT_EN.
module joint_step_driver #(
    parameter int STEP_HIGH   = 4,
    parameter int STEP_PERIOD = 16,
    parameter int DIR_SETUP   = 8,
    parameter int TH1_MIN     = -2048,
    parameter int TH1_MAX     = 2047,
    parameter int TH2_MIN     = -2048,
    parameter int TH2_MAX     = 2047
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [12:0] th1,
    input  logic signed [12:0] th2,
    output logic               step1,
    output logic               step2,
    output logic               dir1,
    output logic               dir2,
    output logic               busy,
    output logic               done,
    output logic               limitHit
);

    typedef enum logic [2:0] {IDLE, LATCH, SETUP, STEP_HI, STEP_LO, DONE} state_t;

    generate
        if (STEP_HIGH < 1 || STEP_PERIOD <= STEP_HIGH || DIR_SETUP < 1 ||
            TH1_MIN > TH1_MAX || TH2_MIN > TH2_MAX) begin : g_bad_params
            $error("joint_step_driver: inconsistent timing or limit parameters");
        end
    endgenerate

    state_t             state, state_d;
    logic [15:0]        cnt, cnt_d;
    logic signed [12:0] tgt1, tgt1_d, tgt2, tgt2_d;
    logic signed [12:0] pos1, pos1_d, pos2, pos2_d;
    logic [12:0]        rem1, rem1_d, rem2, rem2_d;
    logic               step1_d, step2_d, dir1_d, dir2_d, busy_d, done_d;
    logic signed [12:0] eff1, eff2;
    logic               clip1, clip2;
    logic signed [13:0] delta1, delta2, mag1, mag2;

`ifdef JOINT_LIMIT_EN
    function automatic logic signed [12:0] clamp13(input logic signed [12:0] v,
                                                   input int lo, input int hi);
        if (v < lo) return 13'(lo);
        if (v > hi) return 13'(hi);
        return v;
    endfunction

    logic limit_q, limit_d;
    assign limitHit = limit_q;
`else
    assign limitHit = 1'b0;
`endif

    // Signed move per joint, widened to 14 bits so the full 13-bit span cannot overflow.
    always_comb begin
        eff1  = tgt1;
        eff2  = tgt2;
        clip1 = 1'b0;
        clip2 = 1'b0;
`ifdef JOINT_LIMIT_EN
        eff1  = clamp13(tgt1, TH1_MIN, TH1_MAX);
        eff2  = clamp13(tgt2, TH2_MIN, TH2_MAX);
        clip1 = (eff1 != tgt1);
        clip2 = (eff2 != tgt2);
`endif
        delta1 = {eff1[12], eff1} - {pos1[12], pos1};
        delta2 = {eff2[12], eff2} - {pos2[12], pos2};
        mag1   = delta1[13] ? -delta1 : delta1;
        mag2   = delta2[13] ? -delta2 : delta2;
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        tgt1_d  = tgt1;
        tgt2_d  = tgt2;
        pos1_d  = pos1;
        pos2_d  = pos2;
        rem1_d  = rem1;
        rem2_d  = rem2;
        step1_d = step1;
        step2_d = step2;
        dir1_d  = dir1;
        dir2_d  = dir2;
        busy_d  = busy;
        done_d  = 1'b0;
`ifdef JOINT_LIMIT_EN
        limit_d = limit_q;
`endif
        case (state)
            IDLE: begin
                if (enable) begin
                    tgt1_d  = th1;
                    tgt2_d  = th2;
                    busy_d  = 1'b1;
`ifdef JOINT_LIMIT_EN
                    limit_d = 1'b0;
`endif
                    state_d = LATCH;
                end
            end
            LATCH: begin
                tgt1_d = eff1;
                tgt2_d = eff2;
                dir1_d = ~delta1[13];
                dir2_d = ~delta2[13];
                rem1_d = mag1[12:0];
                rem2_d = mag2[12:0];
`ifdef JOINT_LIMIT_EN
                limit_d = clip1 | clip2;
`endif
                if (mag1 == 14'sd0 && mag2 == 14'sd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = 16'(DIR_SETUP - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 16'd0) begin
                    step1_d = (rem1 != 13'd0);
                    step2_d = (rem2 != 13'd0);
                    cnt_d   = 16'(STEP_HIGH - 1);
                    state_d = STEP_HI;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            // Position and remaining count advance as the pulse ends, only for joints that pulsed.
            STEP_HI: begin
                if (cnt == 16'd0) begin
                    step1_d = 1'b0;
                    step2_d = 1'b0;
                    if (step1) begin
                        rem1_d = rem1 - 13'd1;
                        pos1_d = dir1 ? pos1 + 13'sd1 : pos1 - 13'sd1;
                    end
                    if (step2) begin
                        rem2_d = rem2 - 13'd1;
                        pos2_d = dir2 ? pos2 + 13'sd1 : pos2 - 13'sd1;
                    end
                    cnt_d   = 16'(STEP_PERIOD - STEP_HIGH - 1);
                    state_d = STEP_LO;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            STEP_LO: begin
                if (cnt == 16'd0) begin
                    if (rem1 == 13'd0 && rem2 == 13'd0) begin
                        state_d = DONE;
                    end else begin
                        step1_d = (rem1 != 13'd0);
                        step2_d = (rem2 != 13'd0);
                        cnt_d   = 16'(STEP_HIGH - 1);
                        state_d = STEP_HI;
                    end
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            tgt1  <= '0;
            tgt2  <= '0;
            pos1  <= '0;
            pos2  <= '0;
            rem1  <= '0;
            rem2  <= '0;
            step1 <= 1'b0;
            step2 <= 1'b0;
            dir1  <= 1'b0;
            dir2  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef JOINT_LIMIT_EN
            limit_q <= 1'b0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            tgt1  <= tgt1_d;
            tgt2  <= tgt2_d;
            pos1  <= pos1_d;
            pos2  <= pos2_d;
            rem1  <= rem1_d;
            rem2  <= rem2_d;
            step1 <= step1_d;
            step2 <= step2_d;
            dir1  <= dir1_d;
            dir2  <= dir2_d;
            busy  <= busy_d;
            done  <= done_d;
`ifdef JOINT_LIMIT_EN
            limit_q <= limit_d;
`endif
        end
    end

endmodule

// File: tb/tb_joint_step_driver.sv
// Directed bench for joint_step_driver: per-command expectations are queued at issue time and
// compared against what a pin-level monitor measures when done pulses.
module tb_joint_step_driver;

    localparam int STEP_HIGH   = 4;
    localparam int STEP_PERIOD = 16;
    localparam int DIR_SETUP   = 8;
    localparam int WAIT_LIMIT  = 60000;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic signed [12:0] th1, th2;
    logic               step1, step2, dir1, dir2, busy, done, limitHit;

    joint_step_driver #(
        .STEP_HIGH(STEP_HIGH), .STEP_PERIOD(STEP_PERIOD), .DIR_SETUP(DIR_SETUP),
        .TH1_MIN(-2048), .TH1_MAX(2047), .TH2_MIN(-2048), .TH2_MAX(2047)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .th1(th1), .th2(th2),
        .step1(step1), .step2(step2), .dir1(dir1), .dir2(dir2),
        .busy(busy), .done(done), .limitHit(limitHit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c1; int c2; int coinc; int latency; int busyCyc; int firstStep;
        int d1; int d2; int lim; int errs;
    } result_t;

    result_t expQ[$];
    result_t obsQ[$];
    int passCount  = 0;
    int totalCount = 0;
    int cycle      = 0;
    int posM1      = 0;
    int posM2      = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic result_t newResult();
        result_t r;
        r.c1 = 0; r.c2 = 0; r.coinc = 0; r.latency = 0; r.busyCyc = 0; r.firstStep = -1;
        r.d1 = 0; r.d2 = 0; r.lim = 0; r.errs = 0;
        return r;
    endfunction

    // Pin monitor: counts pulses, checks pulse width, period and dir stability per command.
    initial begin : monitor
        logic prev1, prev2, prevBusy, rise1, rise2;
        logic [1:0] prevDir;
        int acceptCycle, hiLen1, hiLen2, lastRise1, lastRise2;
        result_t cur;
        prev1 = 0; prev2 = 0; prevBusy = 0; prevDir = 2'b00;
        acceptCycle = 0; hiLen1 = 0; hiLen2 = 0; lastRise1 = 0; lastRise2 = 0;
        cur = newResult();
        forever begin
            @(negedge clk);
            if (reset) begin
                prev1 = 0; prev2 = 0; prevBusy = 0; hiLen1 = 0; hiLen2 = 0;
                prevDir = {dir1, dir2};
            end else begin
                if (busy && !prevBusy) begin
                    cur = newResult();
                    acceptCycle = cycle;
                end
                rise1 = step1 && !prev1;
                rise2 = step2 && !prev2;
                if (rise1) begin
                    if (cur.c1 > 0 && cycle - lastRise1 != STEP_PERIOD) cur.errs++;
                    lastRise1 = cycle;
                    cur.c1++;
                end
                if (rise2) begin
                    if (cur.c2 > 0 && cycle - lastRise2 != STEP_PERIOD) cur.errs++;
                    lastRise2 = cycle;
                    cur.c2++;
                end
                if ((rise1 || rise2) && cur.firstStep < 0) cur.firstStep = cycle - acceptCycle;
                if (rise1 && rise2) cur.coinc++;
                if (step1) hiLen1++;
                else if (prev1) begin
                    if (hiLen1 != STEP_HIGH) cur.errs++;
                    hiLen1 = 0;
                end
                if (step2) hiLen2++;
                else if (prev2) begin
                    if (hiLen2 != STEP_HIGH) cur.errs++;
                    hiLen2 = 0;
                end
                if ((step1 || step2 || prev1 || prev2) && {dir1, dir2} != prevDir) cur.errs++;
                if (busy) cur.busyCyc++;
                if (done) begin
                    cur.latency = cycle - acceptCycle;
                    cur.d1 = int'(dir1);
                    cur.d2 = int'(dir2);
                    cur.lim = int'(limitHit);
                    obsQ.push_back(cur);
                end
                prev1 = step1; prev2 = step2; prevBusy = busy; prevDir = {dir1, dir2};
            end
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Issues one command and queues what a correct driver must produce for it.
    task automatic applyStimulus(input int t1, input int t2);
        result_t e;
        int tg1, tg2, d1, d2, a1, a2, n, lim;
        tg1 = t1; tg2 = t2; lim = 0;
`ifdef JOINT_LIMIT_EN
        if (tg1 > 2047)  begin tg1 = 2047;  lim = 1; end
        if (tg1 < -2048) begin tg1 = -2048; lim = 1; end
        if (tg2 > 2047)  begin tg2 = 2047;  lim = 1; end
        if (tg2 < -2048) begin tg2 = -2048; lim = 1; end
`endif
        d1 = tg1 - posM1;
        d2 = tg2 - posM2;
        a1 = (d1 < 0) ? -d1 : d1;
        a2 = (d2 < 0) ? -d2 : d2;
        n  = (a1 > a2) ? a1 : a2;
        e = newResult();
        e.c1 = a1; e.c2 = a2; e.coinc = (a1 < a2) ? a1 : a2;
        e.latency   = (n == 0) ? 2 : 2 + DIR_SETUP + n * STEP_PERIOD;
        e.busyCyc   = e.latency;
        e.firstStep = (n == 0) ? -1 : 1 + DIR_SETUP;
        e.d1 = (d1 >= 0) ? 1 : 0;
        e.d2 = (d2 >= 0) ? 1 : 0;
        e.lim = lim;
        expQ.push_back(e);
        posM1 = tg1;
        posM2 = tg2;
        @(negedge clk);
        th1 = 13'(t1);
        th2 = 13'(t2);
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        checkOutput($sformatf("busy_after_accept_%0d_%0d", t1, t2), int'(busy), 1);
    endtask

    task automatic waitResult(input string tag);
        result_t e, o;
        int k;
        k = 0;
        while (obsQ.size() == 0 && k < WAIT_LIMIT) begin
            @(posedge clk);
            k++;
        end
        checkOutput({tag, "_done_seen"}, int'(obsQ.size() > 0), 1);
        if (obsQ.size() > 0 && expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkOutput({tag, "_step1_count"}, o.c1, e.c1);
            checkOutput({tag, "_step2_count"}, o.c2, e.c2);
            checkOutput({tag, "_coincident"}, o.coinc, e.coinc);
            checkOutput({tag, "_done_latency"}, o.latency, e.latency);
            checkOutput({tag, "_busy_cycles"}, o.busyCyc, e.busyCyc);
            checkOutput({tag, "_first_step"}, o.firstStep, e.firstStep);
            checkOutput({tag, "_dir1"}, o.d1, e.d1);
            checkOutput({tag, "_dir2"}, o.d2, e.d2);
            checkOutput({tag, "_limitHit"}, o.lim, e.lim);
            checkOutput({tag, "_pulse_errors"}, o.errs, e.errs);
        end
    endtask

    initial begin : stimulus
        int k;
        reset = 1'b1; enable = 1'b0; th1 = '0; th2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_step1", int'(step1), 0);
        checkOutput("reset_step2", int'(step2), 0);
        checkOutput("reset_dir1", int'(dir1), 0);
        checkOutput("reset_dir2", int'(dir2), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_limitHit", int'(limitHit), 0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(10, 0);
        waitResult("move_pos");
        applyStimulus(-5, -3);
        waitResult("move_neg");
        applyStimulus(-5, -3);
        waitResult("zero_move");

        applyStimulus(20, 7);
        repeat (50) @(negedge clk);
        th1 = 13'sd100;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        th1 = 13'sd20;
        waitResult("ignored_enable");

        applyStimulus(18, 40);
        waitResult("joint2_lead");

        applyStimulus(30, 30);
        k = 0;
        while (!step1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("reach_step_hi", int'(step1), 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midmove_reset_step1", int'(step1), 0);
        checkOutput("midmove_reset_step2", int'(step2), 0);
        checkOutput("midmove_reset_busy", int'(busy), 0);
        expQ.delete();
        posM1 = 0;
        posM2 = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        applyStimulus(4, 0);
        waitResult("after_reset");

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        posM1 = 0;
        posM2 = 0;
        applyStimulus(3000, 0);
        waitResult("limit_3000");

        repeat (4) @(negedge clk);
        checkOutput("no_extra_done", obsQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
